// File: rtl/packetfilt_pkg.sv
// Shared definitions for the packet filter VM and its stream snooper.
// Holds the snooper state encoding, lockout length and drop-counter helpers.
package packetfilt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITING = 2'd1,
        ST_DROP    = 2'd2,
        ST_DONE    = 2'd3
    } snoop_state_e;

    localparam int LOCKOUT_LEN = 2;
    localparam int LOCK_W      = $clog2(LOCKOUT_LEN + 1);
    localparam int DROP_CNT_W  = 32;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/axistream_snooper.sv
// Passive AXI-Stream tap copying accepted packets into the VM packet memory.
// Optional saturating dropped-packet counter: define SNOOPER_DROP_COUNT_EN.
module axistream_snooper
    import packetfilt_pkg::*;
#(
    parameter int SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH           = 64
) (
    input  logic                            axi_aclk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           snoop_TDATA,
    input  logic                            snoop_TVALID,
    input  logic                            snoop_TREADY,
    input  logic                            snoop_TLAST,
    input  logic                            ready_for_snooper,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] snooper_wr_addr,
    output logic [DATA_WIDTH-1:0]           snooper_wr_data,
    output logic                            snooper_wr_en,
`ifdef SNOOPER_DROP_COUNT_EN
    output logic [DROP_CNT_W-1:0]           dropped_count,
`endif
    output logic                            snooper_done
);

    localparam logic [SNOOP_FWD_ADDR_WIDTH-1:0] ADDR_MAX = '1;

    snoop_state_e                    state_q, state_d;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]           wr_data_q, wr_data_d;
    logic                            wr_en_q, wr_en_d;
    logic                            done_q, done_d;
    logic [LOCK_W-1:0]               lock_q, lock_d;

    logic beat;
    logic start_state;
    logic start_ok;

    assign beat        = snoop_TVALID & snoop_TREADY;
    // DONE also accepts first beats; lockout is always active there.
    assign start_state = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start_ok    = ready_for_snooper && (lock_q == '0);

    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) state_d = ST_IDLE;
                if (beat) begin
                    if (start_ok) state_d = snoop_TLAST ? ST_DONE : ST_WRITING;
                    else          state_d = snoop_TLAST ? ST_IDLE : ST_DROP;
                end
            end
            ST_WRITING: if (beat && snoop_TLAST) state_d = ST_DONE;
            ST_DROP:    if (beat && snoop_TLAST) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en_d   = 1'b0;
        done_d    = (state_q == ST_DONE);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        lock_d    = (lock_q != '0) ? lock_q - LOCK_W'(1) : lock_q;
        if (beat && start_state && start_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = snoop_TDATA;
            if (snoop_TLAST) lock_d = LOCK_W'(LOCKOUT_LEN);
        end else if (beat && state_q == ST_WRITING) begin
            // Beyond the last buffer slot the packet is truncated; address holds.
            if (wr_addr_q != ADDR_MAX) begin
                wr_en_d   = 1'b1;
                wr_addr_d = wr_addr_q + 1'b1;
                wr_data_d = snoop_TDATA;
            end
            if (snoop_TLAST) lock_d = LOCK_W'(LOCKOUT_LEN);
        end
    end

    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            lock_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            lock_q    <= lock_d;
        end
    end

    assign snooper_wr_en   = wr_en_q;
    assign snooper_done    = done_q;
    assign snooper_wr_addr = wr_addr_q;
    assign snooper_wr_data = wr_data_q;

`ifdef SNOOPER_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (beat && start_state && !start_ok) drop_cnt_d = sat_inc(drop_cnt_q);
    end

    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign dropped_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axistream_snooper.sv
// Randomised and directed bench for axistream_snooper against a packet-level model.
// Checks dropped_count only when SNOOPER_DROP_COUNT_EN is defined.
module tb_axistream_snooper;

    localparam int AW    = 9;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tdata = '0;
    logic          tvalid = 1'b0, tready = 1'b0, tlast = 1'b0, rfs = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en, done;
    logic [31:0]   dcount;

    always #5 clk = ~clk;

    axistream_snooper #(.SNOOP_FWD_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .axi_aclk          (clk),
        .rst               (rst),
        .snoop_TDATA       (tdata),
        .snoop_TVALID      (tvalid),
        .snoop_TREADY      (tready),
        .snoop_TLAST       (tlast),
        .ready_for_snooper (rfs),
        .snooper_wr_addr   (wr_addr),
        .snooper_wr_data   (wr_data),
        .snooper_wr_en     (wr_en),
`ifdef SNOOPER_DROP_COUNT_EN
        .dropped_count     (dcount),
`endif
        .snooper_done      (done)
    );

`ifndef SNOOPER_DROP_COUNT_EN
    assign dcount = 32'h0;
`endif

    int checks = 0;
    int fails  = 0;

    // Packet-level reference model state
    int            cyc;
    int            last_done_beat;
    bit            in_pkt, keep, done_pend;
    int            idx;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [31:0]   m_drops;
    logic          e_wr, e_done;

    logic [106:0]  obs, expv;

    task automatic model_reset();
        cyc = 0; last_done_beat = -100; in_pkt = 0; keep = 0; done_pend = 0;
        idx = 0; m_addr = '0; m_data = '0; m_drops = '0; e_wr = 0; e_done = 0;
    endtask

    task automatic sample();
`ifdef SNOOPER_DROP_COUNT_EN
        expv = {e_done, e_wr, m_addr, m_data, m_drops};
`else
        expv = {e_done, e_wr, m_addr, m_data, 32'h0};
`endif
        obs = {done, wr_en, wr_addr, wr_data, dcount};
    endtask

    // Drive one cycle of inputs, advance the clock, update model, sample DUT.
    task automatic cycle(input logic v, input logic r, input logic l,
                         input logic [DW-1:0] d, input logic rd);
        tvalid = v; tready = r; tlast = l; tdata = d; rfs = rd;
        @(posedge clk);
        cyc++;
        e_done = done_pend;
        done_pend = 0;
        e_wr = 0;
        if (v && r) begin
            if (!in_pkt) begin
                keep = rd && !((cyc - last_done_beat) <= 2);
                if (!keep && m_drops != 32'hFFFF_FFFF) m_drops++;
                idx = 0;
                in_pkt = 1;
            end else begin
                idx++;
            end
            if (keep && idx < DEPTH) begin
                e_wr = 1; m_addr = AW'(idx); m_data = d;
            end
            if (l) begin
                in_pkt = 0;
                if (keep) begin done_pend = 1; last_done_beat = cyc; end
            end
        end
        #1;
        sample();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        sample();
        checks++;
        if (obs !== expv) begin
            fails++; $display("FAIL reset_state got=%h want=%h", obs, expv);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_three_beat();
        logic [DW-1:0] d [3];
        d[0] = 64'hA; d[1] = 64'hB; d[2] = 64'hC;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, i == 2, d[i], 1);
            checks++;
            if (obs !== expv) begin
                fails++; $display("FAIL three_beat cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, '0, 1);
            checks++;
            if (obs !== expv) begin
                fails++; $display("FAIL three_beat_tail cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_drop_not_ready();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, i == 2, 64'h100 + i, i != 0);
            checks++;
            if (obs !== expv) begin
                fails++; $display("FAIL drop_not_ready cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, '0, 1);
            checks++;
            if (obs !== expv) begin
                fails++; $display("FAIL drop_tail cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_long_packet();
        int n_wr = 0, n_done = 0;
        for (int i = 0; i < 604; i++) begin
            if (i < 600) cycle(1, 1, i == 599, {32'hC0DE, 32'(i)}, 1);
            else         cycle(0, 1, 0, '0, 0);
            n_wr   += int'(wr_en);
            n_done += int'(done);
            checks++;
            if (obs !== expv) begin
                fails++; $display("FAIL long_pkt cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end
        checks++;
        if (n_wr !== DEPTH) begin
            fails++; $display("FAIL long_pkt_writes got=%0d want=%0d", n_wr, DEPTH);
        end
        checks++;
        if (n_done !== 1) begin
            fails++; $display("FAIL long_pkt_done got=%0d want=1", n_done);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            // two single-beat packets back to back, then one after the lockout window
            cycle(i < 2 || i == 5, 1, 1, 64'hBB00 + i, 1);
            checks++;
            if (obs !== expv) begin
                fails++; $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 12; i++) begin
            logic r;
            r = !(i >= 2 && i < 7);
            cycle(i < 9, r, i == 8, 64'h5700 + i, 1);
            checks++;
            if (obs !== expv) begin
                fails++; $display("FAIL stall cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_reset_midpacket();
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, 0, 64'h7700 + i, 1);
            checks++;
            if (obs !== expv) begin
                fails++; $display("FAIL rst_mid_pre cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end
        tvalid = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        sample();
        checks++;
        if (obs !== expv) begin
            fails++; $display("FAIL rst_mid_async got=%h want=%h", obs, expv);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(i < 2, 1, i == 1, 64'h8800 + i, 1);
            checks++;
            if (obs !== expv) begin
                fails++; $display("FAIL rst_mid_post cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, {$urandom, $urandom},
                  $urandom_range(0, 3) != 0);
            checks++;
            if (obs !== expv) begin
                fails++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_beat();
        test_drop_not_ready();
        test_long_packet();
        test_back_to_back();
        test_stall();
        test_reset_midpacket();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
